// File: rtl/montgomery_prescaler.sv
// Montgomery-domain prescaler: T = Y * 2^WIDTH mod N by WIDTH serial
// modular doublings, one per clock. Rejects operands the Montgomery path
// cannot handle (zero or even modulus, Y >= N) with err on the done cycle.
module montgomery_prescaler #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   t;
  logic [WIDTH-1:0]   nn;
  logic               err_r;
  logic               done_r;

  logic [WIDTH:0]     dbl;
  logic [WIDTH-1:0]   dbl_red;
  logic               operands_bad;

  // Doubling step; t < NN guarantees d - NN fits in WIDTH bits, so the
  // subtraction is done modulo 2^WIDTH on the low bits only.
  always_comb begin
    dbl          = {t, 1'b0};
    dbl_red      = dbl[WIDTH-1:0] - nn;
    operands_bad = (n == '0) || !n[0] || (y >= n);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      t      <= '0;
      nn     <= '0;
      err_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nn <= n;
            if (operands_bad) begin
              t      <= '0;
              err_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              t     <= y;
              err_r <= 1'b0;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (dbl >= {1'b0, nn}) t <= dbl_red;
          else                   t <= dbl[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out  = t;
  assign done = done_r;
  assign err  = err_r;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_montgomery_prescaler.sv
// Bench for montgomery_prescaler: a WIDTH=256 instance and a WIDTH=8
// instance, checked against (y * 2^W) mod n computed with wide arithmetic.
module tb_montgomery_prescaler;

  localparam int W  = 256;
  localparam int WS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] y = '0, n = '0;
  logic [W-1:0] out;
  logic         done, err, busy;

  logic          s_start = 1'b0;
  logic [WS-1:0] s_y = '0, s_n = '0;
  logic [WS-1:0] s_out;
  logic          s_done, s_err, s_busy;

  montgomery_prescaler #(.WIDTH(W), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .y(y), .n(n),
    .out(out), .done(done), .err(err), .busy(busy)
  );

  montgomery_prescaler #(.WIDTH(WS), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .y(s_y), .n(s_n),
    .out(s_out), .done(s_done), .err(s_err), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [2*W-1:0] p, q;
    p = {a, {W{1'b0}}};
    q = p % {{W{1'b0}}, m};
    return q[W-1:0];
  endfunction

  function automatic bit ref_bad(input logic [W-1:0] a, input logic [W-1:0] m);
    return (m == 0) || (m % 2 == 0) || (a >= m);
  endfunction

  // Drives one request on the big instance (called at edge+1) and returns
  // when done is seen or the cycle budget runs out.
  task automatic run_big(input logic [W-1:0] ya, input logic [W-1:0] na,
                         output logic [W-1:0] o, output logic e, output int lat);
    start = 1'b1; y = ya; n = na;
    @(posedge clk); #1;
    start = 1'b0; y = rand_w(); n = rand_w();
    lat = 1;
    while (!done && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out; e = err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_cmp++;
    if ({out, done, err, busy} !== '0) begin
      n_bad++; $display("FAIL reset_big: out=%h done=%b err=%b busy=%b required all 0", out, done, err, busy);
    end
    n_cmp++;
    if ({s_out, s_done, s_err, s_busy} !== '0) begin
      n_bad++; $display("FAIL reset_small: out=%h done=%b err=%b busy=%b required all 0", s_out, s_done, s_err, s_busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    int lat, exp_v;
    for (int k = 0; k < 25; k++) begin
      int yv, nv;
      if (k == 0) begin yv = 3; nv = 7; end
      else begin
        nv = $urandom_range(255, 1) | 1;
        yv = $urandom_range(nv - 1, 0);
      end
      exp_v = (yv * 256) % nv;
      s_start = 1'b1; s_y = WS'(yv); s_n = WS'(nv);
      @(posedge clk); #1;
      s_start = 1'b0; s_y = WS'($urandom); s_n = WS'($urandom);
      if (k == 0) begin
        n_cmp++;
        if (s_busy !== 1'b1) begin
          n_bad++; $display("FAIL small_busy: busy=%b required 1", s_busy);
        end
      end
      lat = 1;
      while (!s_done && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat != WS + 1) begin
        n_bad++; $display("FAIL small_latency: y=%0d n=%0d got %0d required %0d", yv, nv, lat, WS + 1);
      end
      n_cmp++;
      if (s_out !== WS'(exp_v) || s_err !== 1'b0) begin
        n_bad++; $display("FAIL small_result: y=%0d n=%0d out=%0d err=%b required out=%0d err=0", yv, nv, s_out, s_err, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat;
    for (int k = 0; k < 3; k++) begin
      na = '1;
      ya = '0;
      if (k == 0) ya = 1;
      if (k == 2) begin ya[W-1] = 1'b1; na = na - 188; end
      run_big(ya, na, o, e, lat);
      n_cmp++;
      if (lat != W + 1) begin
        n_bad++; $display("FAIL basic_latency[%0d]: got %0d required %0d", k, lat, W + 1);
      end
      n_cmp++;
      if (o !== ref_mod(ya, na) || e !== 1'b0) begin
        n_bad++; $display("FAIL basic_result[%0d]: out=%h err=%b required out=%h err=0", k, o, e, ref_mod(ya, na));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat;
    for (int k = 0; k < 6; k++) begin
      na = rand_w() | 1;
      if (k == 0) na = {{(W-8){1'b0}}, 8'hC5};
      ya = rand_w() % na;
      run_big(ya, na, o, e, lat);
      n_cmp++;
      if (lat != W + 1 || o !== ref_mod(ya, na) || e !== 1'b0) begin
        n_bad++; $display("FAIL random_result[%0d]: lat=%0d out=%h err=%b required lat=%0d out=%h err=0", k, lat, o, e, W + 1, ref_mod(ya, na));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_error();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin ya = 5; na = 4; end
        1: begin ya = 0; na = 0; end
        2: begin ya = 7; na = 7; end
        3: begin na = rand_w() | 1; ya = na + 1; if (ya == 0) ya = na; end
        default: begin na = rand_w() | 1; ya = rand_w() % na; end
      endcase
      run_big(ya, na, o, e, lat);
      if (k < 4) begin
        n_cmp++;
        if (lat != 1 || e !== 1'b1 || o !== '0) begin
          n_bad++; $display("FAIL error_path[%0d]: lat=%0d err=%b out=%h required lat=1 err=1 out=0", k, lat, e, o);
        end
        n_cmp++;
        if (ref_bad(ya, na) !== 1'b1) begin
          n_bad++; $display("FAIL error_model[%0d]: model says valid, required invalid", k);
        end
      end else begin
        n_cmp++;
        if (e !== 1'b0 || o !== ref_mod(ya, na)) begin
          n_bad++; $display("FAIL error_clear: err=%b out=%h required err=0 out=%h", e, o, ref_mod(ya, na));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat;
    na = rand_w() | 1; ya = rand_w() % na;
    run_big(ya, na, o, e, lat);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: done=%b busy=%b required 0 0 after done cycle", done, busy);
    end
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (out !== ref_mod(ya, na) || err !== 1'b0) begin
      n_bad++; $display("FAIL hold_out: out=%h err=%b required %h 0", out, err, ref_mod(ya, na));
    end
    run_big(5, 4, o, e, lat);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (err !== 1'b1 || out !== '0) begin
      n_bad++; $display("FAIL hold_err: err=%b out=%h required 1 0", err, out);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] ya, na;
    int c, busy_low;
    na = rand_w() | 1; ya = rand_w() % na;
    start = 1'b1; y = ya; n = na;
    @(posedge clk); #1;
    c = 1; busy_low = 0;
    while (!done && c < 600) begin
      if (!busy) busy_low++;
      start = (c == 5 || c == 100);
      y = rand_w(); n = rand_w();
      @(posedge clk); #1; c++;
    end
    start = 1'b0;
    n_cmp++;
    if (c != W + 1 || busy_low != 0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL ignore_timing: lat=%0d busy_low=%0d busy=%b required lat=%0d 0 1", c, busy_low, busy, W + 1);
    end
    n_cmp++;
    if (out !== ref_mod(ya, na) || err !== 1'b0) begin
      n_bad++; $display("FAIL ignore_result: out=%h err=%b required %h 0", out, err, ref_mod(ya, na));
    end
    c = 0;
    repeat (300) begin @(posedge clk); #1; if (done) c++; end
    n_cmp++;
    if (c != 0) begin
      n_bad++; $display("FAIL ignore_extra_done: %0d extra done pulses, required 0", c);
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat, seen;
    na = rand_w() | 1; ya = (rand_w() % na) | 1;
    start = 1'b1; y = ya; n = na;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({out, done, err, busy} !== '0) begin
      n_bad++; $display("FAIL reset_midrun: out=%h done=%b err=%b busy=%b required all 0", out, done, err, busy);
    end
    #3 reset = 1'b0;
    seen = 0;
    repeat (300) begin @(posedge clk); #1; if (done) seen++; end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL reset_no_done: %0d done pulses, required 0", seen);
    end
    run_big(ya, na, o, e, lat);
    n_cmp++;
    if (lat != W + 1 || o !== ref_mod(ya, na) || e !== 1'b0) begin
      n_bad++; $display("FAIL reset_fresh: lat=%0d out=%h err=%b required %0d %h 0", lat, o, e, W + 1, ref_mod(ya, na));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o, ya, na;
    logic e;
    int lat;
    // run_big returns in the done cycle; the next call raises start in the
    // following (IDLE) cycle, giving the minimum WIDTH+2 spacing.
    for (int k = 0; k < 3; k++) begin
      na = rand_w() | 1; ya = rand_w() % na;
      @(posedge clk); #1;
      run_big(ya, na, o, e, lat);
      n_cmp++;
      if (lat != W + 1 || o !== ref_mod(ya, na) || e !== 1'b0) begin
        n_bad++; $display("FAIL back_to_back[%0d]: lat=%0d out=%h err=%b required %0d %h 0", k, lat, o, e, W + 1, ref_mod(ya, na));
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_basic();
    test_random();
    test_error();
    test_hold();
    @(posedge clk); #1;
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
